// File: rtl/register_bank_pkg.sv
// Shared TD4 register-file constants: default geometry and architectural register indices.
package register_bank_pkg;

  localparam int unsigned TD4_WIDTH = 4;
  localparam int unsigned TD4_NREG  = 4;
  localparam int unsigned TD4_AW    = 2;

  // Architectural register slots within the bank
  localparam int unsigned REG_A   = 0;
  localparam int unsigned REG_B   = 1;
  localparam int unsigned REG_OUT = 2;
  localparam int unsigned REG_PC  = 3;

endpackage

// File: rtl/counter_register.sv
// One bank channel: loadable register with increment mode and a one-cycle wrap pulse.
module counter_register #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LD,
  input  logic             INC,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP
);

  // Priority CLR > LD > INC > hold; WRAP only survives a wrapping increment
  always_ff @(posedge CLK) begin
    if (CLR) begin
      Q    <= RSTVAL;
      WRAP <= 1'b0;
    end else if (LD) begin
      Q    <= D;
      WRAP <= 1'b0;
    end else if (INC) begin
      Q    <= Q + WIDTH'(1);
      WRAP <= (Q == {WIDTH{1'b1}});
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Parametrised register bank: one write port, per-channel increment, two async read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned      WIDTH  = TD4_WIDTH,
  parameter int unsigned      NREG   = TD4_NREG,
  parameter int unsigned      AW     = TD4_AW,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  WE,
  input  logic [AW-1:0]         WADDR,
  input  logic [WIDTH-1:0]      D,
  input  logic [NREG-1:0]       INC,
  input  logic [AW-1:0]         RADDR_A,
  input  logic [AW-1:0]         RADDR_B,
  output logic [WIDTH-1:0]      Q_A,
  output logic [WIDTH-1:0]      Q_B,
  output logic [NREG*WIDTH-1:0] Q_ALL,
  output logic [NREG-1:0]       WRAP
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  ld;

  // Out-of-range write addresses match no channel and are dropped
  always_comb begin
    ld = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      ld[i] = WE && (WADDR == AW'(i));
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_chan
    counter_register #(
      .WIDTH  (WIDTH),
      .RSTVAL (RSTVAL)
    ) u_reg (
      .CLK  (CLK),
      .CLR  (CLR),
      .LD   (ld[g]),
      .INC  (INC[g]),
      .D    (D),
      .Q    (regs[g]),
      .WRAP (WRAP[g])
    );
    assign Q_ALL[g*WIDTH +: WIDTH] = regs[g];
  end

  // Read muxes return zero for addresses beyond the populated range
  always_comb begin
    Q_A = '0;
    Q_B = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (RADDR_A == AW'(i)) Q_A = regs[i];
      if (RADDR_B == AW'(i)) Q_B = regs[i];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed check of register_bank against an array-based reference model.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        clr, we;
  logic [1:0]  waddr, raddr_a, raddr_b;
  logic [3:0]  d, inc;
  logic [3:0]  q_a, q_b, wrap;
  logic [15:0] q_all;
  logic [3:0]  q_a1, q_b1;
  logic [11:0] q_all1;
  logic [2:0]  wrap1;

  int vectors = 0;
  int miscompares = 0;

  int m0 [4];
  int w0 [4];
  int m1 [3];
  int w1 [3];
  bit valid = 1'b0;

  always #5 clk = ~clk;

  register_bank dut (
    .CLK(clk), .CLR(clr), .WE(we), .WADDR(waddr), .D(d), .INC(inc),
    .RADDR_A(raddr_a), .RADDR_B(raddr_b), .Q_A(q_a), .Q_B(q_b),
    .Q_ALL(q_all), .WRAP(wrap)
  );

  register_bank #(.WIDTH(4), .NREG(3), .AW(2), .RSTVAL(4'h0)) dut3 (
    .CLK(clk), .CLR(clr), .WE(we), .WADDR(waddr), .D(d), .INC(inc[2:0]),
    .RADDR_A(raddr_a), .RADDR_B(raddr_b), .Q_A(q_a1), .Q_B(q_b1),
    .Q_ALL(q_all1), .WRAP(wrap1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state of one channel from the behavioural rules
  task automatic chan_next(input int idx, inout int r, inout int w);
    if (clr) begin
      r = 0; w = 0;
    end else if (we && int'(waddr) == idx) begin
      r = int'(d); w = 0;
    end else if (inc[idx]) begin
      w = (r == 15) ? 1 : 0;
      r = (r + 1) % 16;
    end else begin
      w = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) chan_next(i, m0[i], w0[i]);
    for (int i = 0; i < 3; i++) chan_next(i, m1[i], w1[i]);
    if (clr) valid = 1'b1;
  endtask

  function automatic int rd0(input logic [1:0] a);
    return m0[a];
  endfunction

  function automatic int rd1(input logic [1:0] a);
    return (int'(a) < 3) ? m1[a] : 0;
  endfunction

  task automatic compare();
    logic [15:0] eall;
    logic [11:0] eall1;
    logic [3:0]  ewrap;
    logic [2:0]  ewrap1;
    if (!valid) return;
    for (int i = 0; i < 4; i++) begin
      eall[i*4 +: 4] = 4'(m0[i]);
      ewrap[i] = (w0[i] != 0);
    end
    for (int i = 0; i < 3; i++) begin
      eall1[i*4 +: 4] = 4'(m1[i]);
      ewrap1[i] = (w1[i] != 0);
    end
    chk("q_all", 32'(q_all), 32'(eall));
    chk("wrap", 32'(wrap), 32'(ewrap));
    chk("q_a", 32'(q_a), 32'(rd0(raddr_a)));
    chk("q_b", 32'(q_b), 32'(rd0(raddr_b)));
    chk("q_all_n3", 32'(q_all1), 32'(eall1));
    chk("wrap_n3", 32'(wrap1), 32'(ewrap1));
    chk("q_a_n3", 32'(q_a1), 32'(rd1(raddr_a)));
    chk("q_b_n3", 32'(q_b1), 32'(rd1(raddr_b)));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic c, input logic w, input logic [1:0] wa,
                       input logic [3:0] dd, input logic [3:0] ii);
    clr = c; we = w; waddr = wa; d = dd; inc = ii;
  endtask

  initial begin
    raddr_a = 2'd0; raddr_b = 2'd1;
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    #1;

    // Reset then idle
    tick();
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    tick();
    chk("t1_q_all", 32'(q_all), 32'h0000);
    chk("t1_wrap", 32'(wrap), 32'h0);

    // Write reg1 = F, no bypass before the edge
    drive(1'b0, 1'b1, 2'd1, 4'hF, 4'h0);
    #2;
    chk("t2_pre_q_b", 32'(q_b), 32'h0);
    tick();
    chk("t2_q_b", 32'(q_b), 32'hF);
    chk("t2_q_all", 32'(q_all), 32'h00F0);

    // reg3 = E, then count through the wrap
    drive(1'b0, 1'b1, 2'd3, 4'hE, 4'h0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b1000);
    tick();
    chk("t3_reg3_f", 32'(q_all[15:12]), 32'hF);
    chk("t3_wrap_0", 32'(wrap), 32'h0);
    tick();
    chk("t3_reg3_0", 32'(q_all[15:12]), 32'h0);
    chk("t3_wrap_1", 32'(wrap), 32'h8);
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    tick();
    chk("t3_wrap_clr", 32'(wrap), 32'h0);

    // Write beats increment on the same channel
    drive(1'b0, 1'b1, 2'd3, 4'h5, 4'b1001);
    tick();
    chk("t4_q_all", 32'(q_all), 32'h50F1);
    chk("t4_wrap", 32'(wrap), 32'h0);
    chk("t4_q_all_n3", 32'(q_all1), 32'h0F1);

    // Mid-count clear discards count and concurrent write
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0100);
    repeat (3) tick();
    chk("t5_count", 32'(q_all), 32'h53F1);
    drive(1'b1, 1'b1, 2'd2, 4'h7, 4'b0100);
    tick();
    chk("t5_clr", 32'(q_all), 32'h0000);
    chk("t5_clr_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0100);
    tick();
    chk("t5_recount", 32'(q_all), 32'h0100);

    // Out-of-range write and read on the 3-register bank
    raddr_a = 2'd3;
    drive(1'b0, 1'b1, 2'd3, 4'h9, 4'h0);
    tick();
    chk("t6_q_all_n3", 32'(q_all1), 32'h100);
    chk("t6_q_a_n3", 32'(q_a1), 32'h0);
    chk("t6_q_a", 32'(q_a), 32'h9);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom),
            4'($urandom), 4'($urandom));
      raddr_a = 2'($urandom);
      raddr_b = 2'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
